// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory bridge: funct3 access sizes, FSM states, byte strobes.
// Pure declarations and one alignment helper; no timing or flow control of its own.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // funct3[1:0] carries the size; any size code above halfword is treated as a word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
// Purely combinational, zero latency, no flow control.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    sext      = ~funct3[2];
    case (funct3[1:0])
      2'b00:   result = {{24{byte_lane[7] & sext}}, byte_lane};
      2'b01:   result = {{16{half_lane[15] & sext}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Turns the core's single-cycle load/store into a valid/ready bus request plus response wait.
// Best case 3 stall cycles; Stall holds the PC through request backpressure and response wait.
module data_mem_bridge
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic        bus_rsp_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TO_LIMIT = TIMEOUT[15:0];

  logic [1:0]  state_q,    state_d;
  logic [1:0]  lo_q,       lo_d;
  logic [2:0]  f3_q,       f3_d;
  logic [31:0] addr_q,     addr_d;
  logic        we_q,       we_d;
  logic [3:0]  strb_q,     strb_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [31:0] rdata_q,    rdata_d;
  logic        fault_q,    fault_d;
  logic [15:0] cnt_q,      cnt_d;

  logic        access;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_ext;

  assign access = MemRead | MemWrite;

  load_align u_load_align (
    .rdata  (bus_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .result (load_ext)
  );

  // Narrow stores replicate the datum on every lane; the strobe picks the live byte(s).
  always_comb begin
    lane_strb  = STRB_W;
    lane_wdata = WriteData;
    case (funct3[1:0])
      2'b00: begin
        lane_strb  = STRB_B << ALUResult[1:0];
        lane_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        lane_strb  = STRB_H << ALUResult[1:0];
        lane_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    we_d    = we_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          lo_d = ALUResult[1:0];
          f3_d = funct3;
          if (is_aligned(funct3, ALUResult[1:0])) begin
            state_d = S_REQ;
            addr_d  = {ALUResult[31:2], 2'b00};
            we_d    = MemWrite;
            strb_d  = MemWrite ? lane_strb : STRB_NONE;
            wdata_d = MemWrite ? lane_wdata : 32'h0;
          end else begin
            state_d = S_DONE;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = 16'h0;
        end
      end
      S_WAIT: begin
        if (bus_rsp_valid) begin
          state_d = S_DONE;
          fault_d = bus_rsp_err;
          if (bus_rsp_err)
            rdata_d = 32'h0;
          else if (!we_q)
            rdata_d = load_ext;
        end else if (cnt_q == TO_LIMIT) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      strb_q  <= STRB_NONE;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE releases the PC so it advances exactly once per access.
  always_comb begin
    if (state_q == S_IDLE)
      Stall = reset & access;
    else
      Stall = reset & (state_q != S_DONE);
  end

  assign bus_req_valid = (state_q == S_REQ);
  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_wstrb     = strb_q;
  assign bus_wdata     = wdata_q;
  assign ReadData      = rdata_q;
  assign Fault         = fault_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge with a cycle-stepped bus responder and hand-computed expectations.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] ALUResult, WriteData;
  logic [2:0]  funct3;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  logic        r_done, r_fault, r_stable, r_we;
  int          r_cyc, r_stalls, r_nreq, r_faults;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .ALUResult     (ALUResult),
    .WriteData     (WriteData),
    .funct3        (funct3),
    .ReadData      (ReadData),
    .Stall         (Stall),
    .Fault         (Fault),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_err   (bus_rsp_err),
    .bus_rdata     (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One access from the core. rlat = REQ cycles before ready, wlat = WAIT cycles before
  // the response, early = also drive a bogus response before the handshake.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int rlat, input int wlat, input logic err,
                        input logic norsp, input logic early);
    logic hs, req_now, hs_now;
    int   rcnt, wcnt;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd;
    bus_rdata = rdat; bus_rsp_err = err;
    hs = 1'b0; rcnt = 0; wcnt = 0;
    r_done = 1'b0; r_cyc = -1; r_stalls = 0; r_nreq = 0; r_faults = 0;
    r_fault = 1'b0; r_stable = 1'b1; r_rdata = 32'h0;
    r_addr = 32'h0; r_we = 1'b0; r_strb = 4'h0; r_wdata = 32'h0;
    for (int cyc = 0; cyc < 60 && !r_done; cyc++) begin
      bus_req_ready = bus_req_valid && (rcnt >= rlat);
      bus_rsp_valid = (hs && !norsp && (wcnt == wlat)) || (early && !hs);
      @(negedge clk);
      req_now = bus_req_valid;
      hs_now  = bus_req_valid && bus_req_ready;
      if (Fault) r_faults++;
      if (req_now) begin
        r_nreq++;
        if (r_nreq == 1) begin
          r_addr = bus_addr; r_we = bus_we; r_strb = bus_wstrb; r_wdata = bus_wdata;
        end else if (bus_addr !== r_addr || bus_we !== r_we ||
                     bus_wstrb !== r_strb || bus_wdata !== r_wdata) begin
          r_stable = 1'b0;
        end
      end
      if (Stall) r_stalls++;
      else begin
        r_done = 1'b1; r_cyc = cyc; r_fault = Fault; r_rdata = ReadData;
      end
      @(posedge clk); #1;
      if (hs) wcnt++;
      if (hs_now) hs = 1'b1;
      if (req_now) rcnt++;
    end
    MemRead = 1'b0; MemWrite = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
  endtask

  task automatic check_txn(input string name, input int exp_cyc, input logic exp_fault,
                           input int exp_nreq);
    check_eq({name, "/completed"},    32'(r_done), 32'd1);
    check_eq({name, "/done_cycle"},   r_cyc, exp_cyc);
    check_eq({name, "/stall_cycles"}, r_stalls, exp_cyc);
    check_eq({name, "/fault"},        32'(r_fault), 32'(exp_fault));
    check_eq({name, "/fault_pulses"}, r_faults, 32'(exp_fault));
    check_eq({name, "/req_cycles"},   r_nreq, exp_nreq);
    check_eq({name, "/fault_after"},  32'(Fault), 32'd0);
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h104;
    WriteData = 32'h0; funct3 = 3'b010; bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    bus_rsp_err = 1'b0; bus_rdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset/stall",     32'(Stall), 32'd0);
    check_eq("reset/fault",     32'(Fault), 32'd0);
    check_eq("reset/req_valid", 32'(bus_req_valid), 32'd0);
    check_eq("reset/readdata",  ReadData, 32'h0);
    check_eq("reset/addr",      bus_addr, 32'h0);
    check_eq("reset/we",        32'(bus_we), 32'd0);
    check_eq("reset/wstrb",     32'(bus_wstrb), 32'd0);
    check_eq("reset/wdata",     bus_wdata, 32'h0);
    MemRead = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    reset = 1'b1;

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_txn("sw", 3, 1'b0, 1);
    check_eq("sw/addr",  r_addr, 32'h100);
    check_eq("sw/we",    32'(r_we), 32'd1);
    check_eq("sw/wstrb", 32'(r_strb), 32'hF);
    check_eq("sw/wdata", r_wdata, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, 1'b0, 1'b0);
    check_txn("lb", 3, 1'b0, 1);
    check_eq("lb/data",  r_rdata, 32'hFFFF_FF80);
    check_eq("lb/addr",  r_addr, 32'h100);
    check_eq("lb/we",    32'(r_we), 32'd0);
    check_eq("lb/wstrb", 32'(r_strb), 32'h0);

    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("lbu/data", r_rdata, 32'h0000_0080);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("lh/data", r_rdata, 32'hFFFF_80FF);
    access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("lhu/data", r_rdata, 32'h0000_7F01);

    access(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_txn("sb", 3, 1'b0, 1);
    check_eq("sb/addr",  r_addr, 32'h200);
    check_eq("sb/wstrb", 32'(r_strb), 32'h2);
    check_eq("sb/wdata", r_wdata, 32'h7878_7878);

    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("sh/addr",  r_addr, 32'h200);
    check_eq("sh/wstrb", 32'(r_strb), 32'hC);
    check_eq("sh/wdata", r_wdata, 32'h5678_5678);

    access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);
    check_txn("lw_misalign", 1, 1'b1, 0);
    check_eq("lw_misalign/data", r_rdata, 32'h0);

    access(1'b0, 1'b1, 3'b001, 32'h203, 32'hAAAA_5555, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_txn("sh_misalign", 1, 1'b1, 0);

    access(1'b1, 1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D, 32'h0, 5, 0, 1'b0, 1'b0, 1'b0);
    check_txn("backpressure", 8, 1'b0, 6);
    check_eq("backpressure/stable", 32'(r_stable), 32'd1);
    check_eq("backpressure/we",     32'(r_we), 32'd1);
    check_eq("backpressure/addr",   r_addr, 32'h3FC);
    check_eq("backpressure/wdata",  r_wdata, 32'hCAFE_F00D);

    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h1111_1111, 0, 0, 1'b1, 1'b0, 1'b0);
    check_txn("rsp_err", 3, 1'b1, 1);
    check_eq("rsp_err/data", r_rdata, 32'h0);

    access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h1357_9BDF, 0, 3, 1'b0, 1'b0, 1'b0);
    check_txn("slow_rsp", 6, 1'b0, 1);
    check_eq("slow_rsp/data", r_rdata, 32'h1357_9BDF);

    // Abandon a load while it sits in WAIT.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h84;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst/req_valid", 32'(bus_req_valid), 32'd1);
    check_eq("rst/req_addr",  bus_addr, 32'h84);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    check_eq("rst/wait_stall", 32'(Stall), 32'd1);
    check_eq("rst/wait_novld", 32'(bus_req_valid), 32'd0);
    #2 reset = 1'b0;
    #1;
    check_eq("rst/async_stall",    32'(Stall), 32'd0);
    check_eq("rst/async_addr",     bus_addr, 32'h0);
    check_eq("rst/async_readdata", ReadData, 32'h0);
    check_eq("rst/async_wdata",    bus_wdata, 32'h0);
    bus_rsp_valid = 1'b1; bus_rdata = 32'hBAD0_BAD0; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 32'h2468_ACE0, 0, 0, 1'b0, 1'b0, 1'b1);
    check_txn("reissue", 3, 1'b0, 1);
    check_eq("reissue/data", r_rdata, 32'h2468_ACE0);

    access(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 32'h0F0F_0F0F, 0, 0, 1'b0, 1'b1, 1'b0);
    check_txn("timeout", 7, 1'b1, 1);
    check_eq("timeout/data", r_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Load/store bridge between the single-cycle datapath's memory port and a handshaked data-memory bus. It converts the core's combinational access into a multi-cycle bus transaction, and asserts `Stall`, which drives the PC register's `PCWrite` enable low until the access completes. It generates byte strobes and lane-aligned store data, sign- or zero-extends load data, and flags misaligned, errored or timed-out accesses.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for a response (1..65535).
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `MemWrite`  input  1  store request from the control unit.
- `MemRead`  input  1  load request (the control unit's `ResultSrc==2'b01` decode).
- `ALUResult`  input  32  byte address.
- `WriteData`  input  32  store data (from `RD2`).
- `funct3`  input  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `ReadData`  output  32  extended load data, valid in DONE.
- `Stall`  output  1  1 holds the PC; `PCWrite = ~Stall`.
- `Fault`  output  1  one-cycle pulse in DONE on misalign, bus error or timeout.
- `bus_req_valid`  output  1  request valid.
- `bus_req_ready`  input  1  request accepted when this and `bus_req_valid` are both high.
- `bus_addr`  output  32  word address, with `[1:0]` = 0.
- `bus_we`  output  1  1 = write.
- `bus_wstrb`  output  4  byte enables; 0000 on reads.
- `bus_wdata`  output  32  lane-replicated store data.
- `bus_rsp_valid`  input  1  response strobe, for both reads and write acks.
- `bus_rsp_err`  input  1  error qualifier on the response.
- `bus_rdata`  input  32  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - `Stall = MemRead|MemWrite`, driven combinationally.
  - When an access is present, latch the address, size, write flag and data.
  - If the access is aligned, go to REQ. Otherwise go to DONE with `Fault` set.
  - `MemRead&MemWrite` together is a store.
- REQ:
  - `bus_req_valid=1`. `Stall=1`.
  - The address, `bus_we`, `bus_wstrb` and `bus_wdata` outputs are registered and stay stable until the handshake.
  - On handshake, go to WAIT and clear the timeout counter.
- WAIT:
  - `Stall=1`. `bus_req_valid=0`.
  - On `bus_rsp_valid`: capture the extended `bus_rdata`, set `Fault = bus_rsp_err`, and go to DONE.
  - When the counter reaches `TIMEOUT`: go to DONE with `Fault=1` and `ReadData=0`.
- DONE:
  - `Stall=0`, so the PC advances at the end of this cycle.
  - `ReadData` holds its value. `Fault` is high only if flagged.
  - Go to IDLE. DONE never re-issues the access.
- Alignment rules:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=0`.
  - Byte accesses are always aligned.
- Store lanes:
  - Byte: `wstrb = 0001<<addr[1:0]`, and `wdata` is `{4{WriteData[7:0]}}`.
  - Half: `wstrb = 0011<<addr[1:0]`, and `wdata` is `{2{WriteData[15:0]}}`.
  - Word: `wstrb = 1111`.
- Load extension:
  - Lane is selected by `addr[1:0]` for bytes and `addr[1]` for halves.
  - `funct3[2]=0` sign-extends. `funct3[2]=1` zero-extends.
- Faulted loads return `ReadData=0`. Faulted stores have no side effect beyond the bus error itself.
- Responses arriving in IDLE, REQ or DONE are ignored.

## Timing
- Reset values: `ReadData=0`, `Fault=0`, `bus_req_valid=0`, `bus_addr=0`, `bus_we=0`, `bus_wstrb=0`, `bus_wdata=0`, counter 0.
- `Stall` is forced to 0 while `reset` is low.
- Best case for an aligned access, with the access arriving at cycle 0:
  - Cycle 0: IDLE.
  - Cycle 1: REQ, with `ready=1`.
  - Cycle 2: WAIT, with `rsp_valid=1`.
  - Cycle 3: DONE.
  - This gives 3 stall cycles, and the PC updates at the end of cycle 3.
- A misaligned access stalls 1 cycle (IDLE, then DONE).
- The earliest response accepted is in the cycle after the request handshake.
- Timeout: `Fault` is raised `TIMEOUT+1` cycles after entering WAIT.
- A reset asserted mid-transaction abandons it: the FSM returns to IDLE and `bus_req_valid` drops immediately. A late response is ignored. After reset releases, the pending instruction re-issues from IDLE.

## Structure
- Shared package `mem_pkg`:
  - funct3 size encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State encoding (`S_IDLE`, `S_REQ`, `S_WAIT`, `S_DONE`).
  - Strobe constants.
- One combinational sub-module, `load_align`, with inputs `rdata`, `addr[1:0]` and `funct3`, producing the extended 32-bit result.
- The FSM, counter and store-lane logic stay in `data_mem_bridge`.

## Test plan
- **sw, zero-wait bus:** `sw` of 0xDEADBEEF to 0x100, with `ready=1` and a response the next cycle.
  - Bus sees `addr=0x100`, `we=1`, `wstrb=1111`.
  - `Stall` is high for exactly 3 cycles.
  - `Fault=0`.
- **lb / lbu lanes:** `lb` at 0x103, with `bus_rdata=0x80FF7F01`.
  - `ReadData=0xFFFFFF80`.
  - Repeating as `lbu` gives 0x00000080.
  - `lh` at 0x102 gives 0xFFFF80FF.
- **sb strobe and lane replication:** `sb` of 0x12345678 to 0x201.
  - `bus_addr=0x200`, `wstrb=0010`, `wdata=0x78787878`.
- **Misaligned access:** `lw` at 0x102.
  - No `bus_req_valid`.
  - 1 stall cycle, `Fault` pulses, `ReadData=0`.
- **Backpressure, error and timeout:**
  - `ready` held low for 5 cycles: request fields stay stable and `Stall` stays high.
  - Response with `rsp_err=1`: `Fault=1`.
  - With `TIMEOUT=4` and no response: `Fault` is raised 5 cycles after WAIT is entered.
- **Reset mid-WAIT:** assert `reset` during WAIT.
  - All outputs return to their reset values asynchronously.
  - A stale `rsp_valid` after release is ignored.
  - The access re-issues and completes correctly.
